// File: rtl/accel_bus_responder_if.sv
// CPU accelerator bus: handshake, register select and completion.
// The shared 16-bit databus is a tristate net and is carried as a plain
// inout port on the responder, so it is not part of this interface.
interface accel_bus_responder_if;
  logic       bus_en;
  logic       bus_start;
  logic [1:0] bus_rdwr;
  logic [2:0] bus_regaddr;
  logic       bus_done;

  // CPU side
  modport master (
    output bus_en,
    output bus_start,
    output bus_rdwr,
    output bus_regaddr,
    input  bus_done
  );

  // Accelerator side
  modport slave (
    input  bus_en,
    input  bus_start,
    input  bus_rdwr,
    input  bus_regaddr,
    output bus_done
  );
endinterface

// File: rtl/accel_bus_responder.sv
// Responder end of the CPU accelerator bus. Holds a small register file and,
// on start, streams LEN 256-bit words out of DMEM port B, summing every
// signed 16-bit lane into a 32-bit wrapping result.
module accel_bus_responder #(
  parameter int          DMEM_RD_LAT = 1,       // 1 or 2
  parameter logic [15:0] ACC_ID      = 16'hACC1
) (
  input  logic                       clk,
  input  logic                       rst_n,
  accel_bus_responder_if.slave       bus,
  inout  wire  [15:0]                databus,
  output logic                       dmem_rden,
  output logic [6:0]                 dmem_rdaddr,
  input  logic [255:0]               dmem_rddata,
  output logic                       busy
);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  state_t                 r_state;
  state_t                 w_state_nxt;

  // programmer-visible registers
  logic [6:0]             r_src;
  logic [7:0]             r_len;
  logic [31:0]            r_res;
  logic                   r_err;

  // operation context captured at start
  logic [7:0]             r_len_sh;
  logic [7:0]             r_issued;
  logic [6:0]             r_addr;
  logic [DMEM_RD_LAT-1:0] r_vpipe;

  logic                   w_busy;
  logic                   w_start;
  logic                   w_wr;
  logic                   w_rd;
  logic                   w_rden;
  logic                   w_last_issue;
  logic                   w_pipe_empty;
  logic [15:0]            w_rdata;
  logic                   w_unused;

  // Sign-extend each of the 16 lanes of a DMEM word and add them up mod 2^32.
  function automatic logic [31:0] lane_sum(input logic [255:0] word);
    logic [31:0] acc;
    acc = 32'd0;
    for (int i = 0; i < 16; i++) begin
      acc = acc + {{16{word[16*i+15]}}, word[16*i +: 16]};
    end
    return acc;
  endfunction

  assign w_busy       = (r_state == ST_FETCH) || (r_state == ST_DRAIN);
  assign w_start      = bus.bus_en & bus.bus_start;
  // A combined read/write (2'b11) is served as a read only.
  assign w_wr         = bus.bus_en & (bus.bus_rdwr == 2'b01);
  assign w_rd         = bus.bus_en & bus.bus_rdwr[1];
  assign w_rden       = (r_state == ST_FETCH);
  assign w_last_issue = ((r_issued + 8'd1) == r_len_sh);
  assign w_pipe_empty = (r_vpipe == {DMEM_RD_LAT{1'b0}});

  // Upper databus bits carry nothing any register stores.
  assign w_unused     = ^databus[15:8];

  assign busy         = w_busy;
  assign dmem_rden    = w_rden;
  assign dmem_rdaddr  = r_addr;
  assign bus.bus_done = (r_state == ST_DONE) & bus.bus_en;
  assign databus      = w_rd ? w_rdata : 16'hzzzz;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic. A zero-length request passes through DRAIN with an
  // empty pipe so that completion lands one edge after the start.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_start) begin
          if (r_len != 8'd0) begin
            w_state_nxt = ST_FETCH;
          end else begin
            w_state_nxt = ST_DRAIN;
          end
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_FETCH: begin
        if (w_last_issue) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_FETCH;
        end
      end
      ST_DRAIN: begin
        if (w_pipe_empty) begin
          w_state_nxt = ST_DONE;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_DONE: begin
        if (!bus.bus_start) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_DONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Fetch datapath: capture context at start, step the address, track
  // outstanding reads and accumulate each returning word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_len_sh <= 8'd0;
      r_issued <= 8'd0;
      r_addr   <= 7'd0;
      r_res    <= 32'd0;
      r_vpipe  <= {DMEM_RD_LAT{1'b0}};
    end else begin
      r_vpipe[0] <= w_rden;
      for (int i = 1; i < DMEM_RD_LAT; i++) begin
        r_vpipe[i] <= r_vpipe[i-1];
      end

      if ((r_state == ST_IDLE) && w_start) begin
        r_res    <= 32'd0;
        r_issued <= 8'd0;
        r_len_sh <= r_len;
        r_addr   <= r_src;
      end else begin
        if (r_state == ST_FETCH) begin
          r_issued <= r_issued + 8'd1;
          r_addr   <= r_addr + 7'd1;   // wraps 127 -> 0
        end
        if (r_vpipe[DMEM_RD_LAT-1]) begin
          r_res <= r_res + lane_sum(dmem_rddata);
        end
      end
    end
  end

  // Register-file writes. SRC/LEN are locked while an operation runs; an
  // attempt flags err, which software clears by writing bit 1 of STATUS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_src <= 7'd0;
      r_len <= 8'd0;
      r_err <= 1'b0;
    end else if (w_wr) begin
      case (bus.bus_regaddr)
        3'd0: begin
          if (databus[1]) begin
            r_err <= 1'b0;
          end
        end
        3'd1: begin
          if (w_busy) begin
            r_err <= 1'b1;
          end else begin
            r_src <= databus[6:0];
          end
        end
        3'd2: begin
          if (w_busy) begin
            r_err <= 1'b1;
          end else begin
            r_len <= databus[7:0];
          end
        end
        default: begin
          r_err <= r_err;
        end
      endcase
    end
  end

  // Read mux, combinational from the registers.
  always_comb begin
    w_rdata = 16'h0000;
    case (bus.bus_regaddr)
      3'd0:    w_rdata = {14'b0, r_err, w_busy};
      3'd1:    w_rdata = {9'b0, r_src};
      3'd2:    w_rdata = {8'b0, r_len};
      3'd3:    w_rdata = r_res[15:0];
      3'd4:    w_rdata = r_res[31:16];
      3'd5:    w_rdata = ACC_ID;
      default: w_rdata = 16'h0000;
    endcase
  end

endmodule

// File: tb/tb_accel_bus_responder.sv
// Directed bench for accel_bus_responder with a latency-1 DMEM model.
module tb_accel_bus_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n;
  tri1 [15:0]   databus;
  logic         tb_drv;
  logic [15:0]  tb_wdata;
  logic         dmem_rden;
  logic [6:0]   dmem_rdaddr;
  logic [255:0] dmem_rddata;
  logic         busy;

  accel_bus_responder_if bus_if ();

  assign databus = tb_drv ? tb_wdata : 16'hzzzz;

  accel_bus_responder #(.DMEM_RD_LAT(1), .ACC_ID(16'hACC1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bus         (bus_if),
    .databus     (databus),
    .dmem_rden   (dmem_rden),
    .dmem_rdaddr (dmem_rdaddr),
    .dmem_rddata (dmem_rddata),
    .busy        (busy)
  );

  // DMEM port B model, one-cycle read latency
  logic [255:0] mem [0:127];
  always @(posedge clk) begin
    if (dmem_rden) dmem_rddata <= mem[dmem_rdaddr];
  end

  // log of issued read addresses
  int         n_iss = 0;
  logic [6:0] iss_addr [0:255];
  always @(posedge clk) begin
    if (dmem_rden) begin
      iss_addr[n_iss[7:0]] <= dmem_rdaddr;
      n_iss <= n_iss + 1;
    end
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [2:0] a, input logic [15:0] d);
    bus_if.bus_en      = 1'b1;
    bus_if.bus_rdwr    = 2'b01;
    bus_if.bus_regaddr = a;
    tb_wdata           = d;
    tb_drv             = 1'b1;
    tick();
    tb_drv             = 1'b0;
    bus_if.bus_rdwr    = 2'b00;
  endtask

  task automatic bus_rd(input logic [2:0] a, output logic [15:0] d);
    bus_if.bus_en      = 1'b1;
    bus_if.bus_rdwr    = 2'b10;
    bus_if.bus_regaddr = a;
    #1;
    d = databus;
    bus_if.bus_rdwr    = 2'b00;
  endtask

  // count edges after the start edge until bus_done rises (bounded)
  task automatic wait_done(inout int k);
    while (!bus_if.bus_done && k < 60) begin
      tick();
      k++;
    end
  endtask

  function automatic logic [255:0] fill(input logic [15:0] v);
    logic [255:0] w;
    for (int i = 0; i < 16; i++) w[16*i +: 16] = v;
    return w;
  endfunction

  logic [15:0]  rd_v;
  logic [255:0] tmp;
  int           k;
  int           base;
  int           good;

  initial begin
    rst_n              = 1'b0;
    tb_drv             = 1'b0;
    tb_wdata           = 16'h0000;
    bus_if.bus_en      = 1'b0;
    bus_if.bus_start   = 1'b0;
    bus_if.bus_rdwr    = 2'b00;
    bus_if.bus_regaddr = 3'd0;
    for (int i = 0; i < 128; i++) mem[i] = 256'd0;
    mem[3]   = fill(16'h0001);
    mem[4]   = fill(16'hFFFE);
    for (int i = 0; i < 16; i++) tmp[16*i +: 16] = 16'(i);
    mem[126] = tmp;
    mem[127] = fill(16'h8000);
    mem[0]   = fill(16'h7FFF);
    mem[1]   = fill(16'h0100);

    tick(); tick();
    rst_n = 1'b1;
    tick();

    // ---- reset state ----
    bus_if.bus_en = 1'b1;
    #1;
    check_val("rst_done", bus_if.bus_done, 1'b0);
    check_val("rst_rden", dmem_rden, 1'b0);
    check_val("rst_busy", busy, 1'b0);
    bus_if.bus_en = 1'b0;
    #1;
    check_val("rst_bus_z", databus, 16'hFFFF);
    bus_rd(3'd0, rd_v); check_val("rst_status", rd_v, 16'h0000);
    bus_rd(3'd1, rd_v); check_val("rst_src", rd_v, 16'h0000);
    bus_rd(3'd2, rd_v); check_val("rst_len", rd_v, 16'h0000);
    bus_rd(3'd3, rd_v); check_val("rst_res_lo", rd_v, 16'h0000);
    bus_rd(3'd5, rd_v); check_val("rst_id", rd_v, 16'hACC1);
    tick();
    bus_rd(3'd6, rd_v); check_val("rst_reg6", rd_v, 16'h0000);

    // ---- SRC=3 LEN=2, lanes 1 then -2 ----
    bus_wr(3'd1, 16'hFF83);
    bus_wr(3'd2, 16'h1202);
    bus_rd(3'd1, rd_v); check_val("src_mask", rd_v, 16'h0003);
    bus_rd(3'd2, rd_v); check_val("len_mask", rd_v, 16'h0002);
    base = n_iss;
    bus_if.bus_start = 1'b1;
    tick();                       // edge 0
    k = 0;
    wait_done(k);
    check_val("t2_done_edge", k, 4);
    check_val("t2_n_iss", n_iss - base, 2);
    check_val("t2_addr0", iss_addr[base], 7'd3);
    check_val("t2_addr1", iss_addr[base+1], 7'd4);
    bus_rd(3'd3, rd_v); check_val("t2_res_lo", rd_v, 16'hFFF0);
    bus_rd(3'd4, rd_v); check_val("t2_res_hi", rd_v, 16'hFFFF);
    bus_rd(3'd0, rd_v); check_val("t2_status_done", rd_v, 16'h0000);
    good = 0;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (bus_if.bus_done) good++;
    end
    check_val("t2_done_held", good, 5);
    bus_if.bus_en = 1'b0;
    #1;
    check_val("t2_done_en_low", bus_if.bus_done, 1'b0);
    bus_if.bus_en = 1'b1;
    bus_if.bus_start = 1'b0;
    tick();
    check_val("t2_idle_after_drop", bus_if.bus_done, 1'b0);

    // ---- LEN=0 ----
    bus_wr(3'd2, 16'h0000);
    base = n_iss;
    bus_if.bus_start = 1'b1;
    tick();
    k = 0;
    wait_done(k);
    check_val("t3_done_edge", k, 1);
    check_val("t3_n_iss", n_iss - base, 0);
    bus_rd(3'd3, rd_v); check_val("t3_res_lo", rd_v, 16'h0000);
    bus_rd(3'd4, rd_v); check_val("t3_res_hi", rd_v, 16'h0000);
    bus_if.bus_start = 1'b0;
    tick();

    // ---- SRC=126 LEN=4 wrap, write LEN while busy ----
    bus_wr(3'd1, 16'd126);
    bus_wr(3'd2, 16'd4);
    base = n_iss;
    bus_if.bus_start = 1'b1;
    tick();                       // edge 0
    bus_wr(3'd2, 16'd9);          // edge 1, while busy
    k = 1;
    bus_rd(3'd0, rd_v); check_val("t4_status_err", rd_v, 16'h0003);
    bus_rd(3'd2, rd_v); check_val("t4_len_kept", rd_v, 16'h0004);
    wait_done(k);
    check_val("t4_done_edge", k, 6);
    check_val("t4_n_iss", n_iss - base, 4);
    check_val("t4_addr0", iss_addr[base], 7'd126);
    check_val("t4_addr1", iss_addr[base+1], 7'd127);
    check_val("t4_addr2", iss_addr[base+2], 7'd0);
    check_val("t4_addr3", iss_addr[base+3], 7'd1);
    bus_rd(3'd3, rd_v); check_val("t4_res_lo", rd_v, 16'h1068);
    bus_rd(3'd4, rd_v); check_val("t4_res_hi", rd_v, 16'h0000);
    bus_rd(3'd0, rd_v); check_val("t4_status_done", rd_v, 16'h0002);
    bus_wr(3'd0, 16'h0002);
    bus_rd(3'd0, rd_v); check_val("t4_err_cleared", rd_v, 16'h0000);
    bus_if.bus_start = 1'b0;
    tick();

    // ---- async reset mid-FETCH ----
    bus_wr(3'd1, 16'd0);
    bus_wr(3'd2, 16'd20);
    bus_if.bus_start = 1'b1;
    tick();
    tick();
    tick();
    check_val("t5_rden_fetch", dmem_rden, 1'b1);
    bus_if.bus_en = 1'b0;
    rst_n = 1'b0;
    #1;
    check_val("t5_rst_rden", dmem_rden, 1'b0);
    check_val("t5_rst_bus_z", databus, 16'hFFFF);
    check_val("t5_rst_busy", busy, 1'b0);
    bus_if.bus_start = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    bus_rd(3'd3, rd_v); check_val("t5_res_lo", rd_v, 16'h0000);
    bus_rd(3'd4, rd_v); check_val("t5_res_hi", rd_v, 16'h0000);
    bus_rd(3'd5, rd_v); check_val("t5_id", rd_v, 16'hACC1);
    bus_rd(3'd2, rd_v); check_val("t5_len", rd_v, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
